lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store controller sitting directly upstream of the data-memory block; it feeds that block's valid/raddr/mem_wen/waddr/wmask/wdata inputs and consumes its rdata.
- Accepts one load or store per request from the execute stage over a valid/ready handshake.
- Word-aligns the address, builds the byte mask and shifts the store data.
- Extracts and sign- or zero-extends load data.
- Returns a registered response over a second valid/ready handshake.
- Reports misaligned accesses and illegal funct3 without touching memory.

Parameters:
MEM_LATENCY, 1, cycles mem_valid is held per access (>=1); mem_rdata sampled in the last one

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_wen  input  1  1=store, 0=load
req_funct3  input  3  RV32 width/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  extended load data (0 for stores/errors)
resp_err  output  1  misaligned or illegal funct3
mem_valid  output  1  to memory valid
mem_raddr  output  32  word-aligned read address
mem_wen  output  1  to memory write enable
mem_waddr  output  32  word-aligned write address
mem_wmask  output  8  byte mask; bits[7:4] always 0
mem_wdata  output  32  lane-shifted store data
mem_rdata  input  32  combinational read data from memory

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE; all outputs 0 except req_ready=1. Reset mid-operation aborts the transfer, drops any pending response, and deasserts mem_valid/mem_wen immediately; no retry.
- Request acceptance:
  - Request accepted on a clk edge with req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - req_wen, req_funct3, req_addr and req_wdata are registered at acceptance.
- State IDLE: on acceptance, go to RESP with resp_err=1 if the request is illegal, else to ACCESS.
- Illegal requests:
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010};
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0.
- State ACCESS:
  - mem_valid=1 for MEM_LATENCY cycles (internal counter).
  - mem_raddr = mem_waddr = {addr[31:2],2'b00}.
  - mem_wen=1 only in the first ACCESS cycle and only for stores, so the memory writes exactly once.
  - In the last cycle, mem_rdata is captured and the state moves to RESP.
- State RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid && resp_ready, then the state returns to IDLE.
  - No new request is accepted in the same cycle as the handshake.
- Latency: response visible MEM_LATENCY+1 cycles after the acceptance edge (1 cycle for errors); throughput is one request per MEM_LATENCY+2 cycles.
- Store lanes, with off = addr[1:0]:
  - SB: wmask = 1<<off, wdata = req_wdata[7:0] << 8*off.
  - SH: wmask = 3<<off, wdata = req_wdata[15:0] << 8*off.
  - SW: wmask = 0x0F, wdata = req_wdata.
- Load extract: shifted = mem_rdata >> 8*off, then:
  - LB: sign-extend [7:0]
  - LH: sign-extend [15:0]
  - LW: as is
  - LBU: zero-extend [7:0]
  - LHU: zero-extend [15:0]
- Outside ACCESS: mem_valid=0, mem_wen=0, mem_wmask=0; the address and data outputs are don't-care but must be driven (use 0).
- resp_rdata=0 for stores and errors.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/H/W/BU/HU;
  - state enum {IDLE, ACCESS, RESP};
  - MASK_W=8.
- Sub-module lsu_align: purely combinational. Takes funct3 and off; produces the store mask, shifted wdata and extended load data. Lets the lane logic be unit-tested separately from the FSM.

Test Plan:
- LW at 0x80000010, mem_rdata=0xDEADBEEF, MEM_LATENCY=1 -> mem_raddr=0x80000010, one mem_valid cycle, mem_wen=0; resp_rdata=0xDEADBEEF, resp_err=0, two cycles after acceptance.
- LB at 0x80000003, mem_rdata=0x80123456 -> resp_rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x80000002 -> 0x00008012.
- SH at 0x80000002, req_wdata=0xABCD1234 -> mem_waddr=0x80000000, mem_wmask=0x0C, mem_wdata=0x12340000, mem_wen high exactly one cycle; resp_rdata=0.
- LW at 0x80000001 and store with funct3=011 -> resp_err=1 one cycle later; mem_valid never asserted.
- Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout; accepted again the cycle after the handshake.
- MEM_LATENCY=3, assert rst in the second ACCESS cycle -> mem_valid drops without a clock edge, req_ready=1, no resp_valid; next SW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store controller.
package lsu_pkg;

    localparam int MASK_W = 8;

    // RV32 load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // True when the request must be rejected without touching memory:
    // unknown width code for its direction, or an address not aligned to the width.
    function automatic logic is_illegal(input logic wen, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic bad_code;
        logic bad_align;
        bad_code  = 1'b0;
        bad_align = 1'b0;
        if (wen) begin
            bad_code = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
        end else begin
            bad_code = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            bad_align = off[0];
        end
        if (f3 == F3_W) begin
            bad_align = (off != 2'b00);
        end
        return bad_code || bad_align;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store mask and data placement, load extraction and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    output logic [MASK_W-1:0] wmask,
    output logic [31:0]       wdata_sh,
    output logic [31:0]       rdata_ext
);

    logic [4:0]  sh_amt;
    logic [31:0] rd_sh;

    assign sh_amt = {off, 3'b000};
    assign rd_sh  = rdata >> sh_amt;

    // Lane selection per width code; unused codes leave everything at zero
    always_comb begin
        wmask     = '0;
        wdata_sh  = '0;
        rdata_ext = '0;
        case (funct3)
            F3_B: begin
                wmask     = {4'b0000, 4'b0001 << off};
                wdata_sh  = {24'b0, wdata[7:0]} << sh_amt;
                rdata_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            end
            F3_H: begin
                wmask     = {4'b0000, 4'b0011 << off};
                wdata_sh  = {16'b0, wdata[15:0]} << sh_amt;
                rdata_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            end
            F3_W: begin
                wmask     = 8'h0F;
                wdata_sh  = wdata;
                rdata_ext = rd_sh;
            end
            F3_BU: begin
                rdata_ext = {24'b0, rd_sh[7:0]};
            end
            F3_HU: begin
                rdata_ext = {16'b0, rd_sh[15:0]};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time, memory access held for
// MEM_LATENCY cycles, registered response held until taken.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    output logic [31:0]       mem_raddr,
    output logic              mem_wen,
    output logic [31:0]       mem_waddr,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t           state_q, state_d;
    logic             wen_q, wen_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [MASK_W-1:0] al_wmask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;

    lsu_align u_align (
        .funct3    (funct3_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wmask     (al_wmask),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    // State and request/response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wen_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wen_q    <= wen_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state and output decode; outputs are purely a function of state so
    // an asynchronous reset drops mem_valid/mem_wen at once
    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_valid  = 1'b0;
        mem_raddr  = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wmask  = '0;
        mem_wdata  = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    wen_d    = req_wen;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    if (is_illegal(req_wen, req_funct3, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_valid = 1'b1;
                mem_raddr = {addr_q[31:2], 2'b00};
                mem_waddr = {addr_q[31:2], 2'b00};
                // write strobe only on the first beat so a held access writes once
                mem_wen   = wen_q && (cnt_q == '0);
                mem_wmask = wen_q ? al_wmask : '0;
                mem_wdata = wen_q ? al_wdata : '0;
                if (cnt_q == CNT_LAST) begin
                    rdata_d = wen_q ? 32'h0 : al_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench: a timeline model of each transaction is compared with
// the DUT every cycle, plus literal expectations for the directed vectors.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;        // 0: MEM_LATENCY=1 instance, 1: MEM_LATENCY=3 instance
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        rr1, rv1, re1, mv1, mw1, rr3, rv3, re3, mv3, mw3;
    logic [31:0] rd1, ra1, wa1, wd1, rd3, ra3, wa3, wd3;
    logic [7:0]  wm1, wm3;

    logic        d_req_ready, d_resp_valid, d_resp_err, d_mem_valid, d_mem_wen;
    logic [31:0] d_resp_rdata, d_mem_raddr, d_mem_waddr, d_mem_wdata;
    logic [7:0]  d_mem_wmask;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr1),
        .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_ready(resp_ready & ~sel), .resp_rdata(rd1), .resp_err(re1),
        .mem_valid(mv1), .mem_raddr(ra1), .mem_wen(mw1), .mem_waddr(wa1),
        .mem_wmask(wm1), .mem_wdata(wd1), .mem_rdata(mem_rdata)
    );

    lsu_mem_ctrl #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr3),
        .req_wen(req_wen), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv3), .resp_ready(resp_ready & sel), .resp_rdata(rd3), .resp_err(re3),
        .mem_valid(mv3), .mem_raddr(ra3), .mem_wen(mw3), .mem_waddr(wa3),
        .mem_wmask(wm3), .mem_wdata(wd3), .mem_rdata(mem_rdata)
    );

    assign d_req_ready  = sel ? rr3 : rr1;
    assign d_resp_valid = sel ? rv3 : rv1;
    assign d_resp_rdata = sel ? rd3 : rd1;
    assign d_resp_err   = sel ? re3 : re1;
    assign d_mem_valid  = sel ? mv3 : mv1;
    assign d_mem_raddr  = sel ? ra3 : ra1;
    assign d_mem_wen    = sel ? mw3 : mw1;
    assign d_mem_waddr  = sel ? wa3 : wa1;
    assign d_mem_wmask  = sel ? wm3 : wm1;
    assign d_mem_wdata  = sel ? wd3 : wd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model (from the access rules) ----------------
    function automatic logic m_legal(input logic wen, input logic [2:0] f3, input logic [31:0] a);
        if (wen && f3 > 3'd2) return 1'b0;
        if (!wen && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        if (f3[1:0] == 2'd1 && a[0]) return 1'b0;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_rdata(input logic wen, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] mem);
        logic [31:0] sh;
        if (wen || !m_legal(wen, f3, a)) return 32'h0;
        sh = mem >> (8 * a[1:0]);
        case (f3)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd1:    return 32'($signed(sh[15:0]));
            3'd4:    return sh & 32'hFF;
            3'd5:    return sh & 32'hFFFF;
            default: return sh;
        endcase
    endfunction

    function automatic logic [7:0] m_wmask(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 8'(1 << a[1:0]);
            3'd1:    return 8'(3 << a[1:0]);
            default: return 8'h0F;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd & 32'hFF) << (8 * a[1:0]);
            3'd1:    return (wd & 32'hFFFF) << (8 * a[1:0]);
            default: return wd;
        endcase
    endfunction

    // Transaction timeline: k = cycles since the acceptance edge
    bit          in_txn = 1'b0;
    int          k = 0;
    logic        m_wen;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wd;
    bit          m_ok;

    function automatic int acc_len();
        return m_ok ? (sel ? 3 : 1) : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            in_txn = 1'b0;
        end else if (in_txn) begin
            if (k > acc_len() && resp_ready) in_txn = 1'b0;
            else k++;
        end else if (req_valid) begin
            in_txn = 1'b1;
            k      = 1;
            m_wen  = req_wen;
            m_f3   = req_funct3;
            m_addr = req_addr;
            m_wd   = req_wdata;
            m_ok   = m_legal(req_wen, req_funct3, req_addr);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!in_txn) begin
            chk("idle_req_ready", d_req_ready, 1);
            chk("idle_mem_valid", d_mem_valid, 0);
            chk("idle_mem_wen", d_mem_wen, 0);
            chk("idle_mem_wmask", d_mem_wmask, 0);
            chk("idle_resp_valid", d_resp_valid, 0);
        end else if (k <= acc_len()) begin
            chk("acc_req_ready", d_req_ready, 0);
            chk("acc_resp_valid", d_resp_valid, 0);
            chk("acc_mem_valid", d_mem_valid, 1);
            chk("acc_mem_wen", d_mem_wen, (m_wen && k == 1) ? 1 : 0);
            chk("acc_mem_raddr", d_mem_raddr, {m_addr[31:2], 2'b00});
            chk("acc_mem_waddr", d_mem_waddr, {m_addr[31:2], 2'b00});
            if (m_wen) begin
                chk("acc_mem_wmask", d_mem_wmask, m_wmask(m_f3, m_addr));
                chk("acc_mem_wdata", d_mem_wdata, m_wdata(m_f3, m_addr, m_wd));
            end
        end else begin
            chk("resp_req_ready", d_req_ready, 0);
            chk("resp_mem_valid", d_mem_valid, 0);
            chk("resp_mem_wen", d_mem_wen, 0);
            chk("resp_valid", d_resp_valid, 1);
            chk("resp_rdata", d_resp_rdata, m_rdata(m_wen, m_f3, m_addr, mem_rdata));
            chk("resp_err", d_resp_err, m_ok ? 0 : 1);
        end
    end

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          vcyc;
        int          wcyc;
        int          acc_wait;
        logic [7:0]  wm;
        logic [31:0] wd;
        logic [31:0] wa;
    } txn_res_t;

    task automatic txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mrd, input int hold,
                       output txn_res_t r);
        r = '{rd: '0, err: 1'b0, lat: 0, vcyc: 0, wcyc: 0, acc_wait: 0, wm: '0, wd: '0, wa: '0};
        req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = mrd; resp_ready = 1'b0; req_valid = 1'b1;
        while (!d_req_ready && r.acc_wait < 20) begin
            @(negedge clk);
            r.acc_wait++;
        end
        if (!d_req_ready) chk("accept_timeout", d_req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            r.lat++;
            if (d_mem_valid) begin
                r.vcyc++;
                r.wm = d_mem_wmask; r.wd = d_mem_wdata; r.wa = d_mem_waddr;
            end
            if (d_mem_wen) r.wcyc++;
        end while (!d_resp_valid && r.lat < 50);
        chk("resp_seen", d_resp_valid, 1);
        r.rd = d_resp_rdata;
        r.err = d_resp_err;
        repeat (hold) @(negedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        $display("txn wen=%0b f3=%0d addr=%h wdata=%h mem=%h -> rdata=%h err=%0b lat=%0d",
                 wen, f3, addr, wdata, mrd, r.rd, r.err, r.lat);
    endtask

    txn_res_t r;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", d_req_ready, 1);
        chk("rst_resp_valid", d_resp_valid, 0);
        chk("rst_mem_valid", d_mem_valid, 0);
        chk("rst_resp_rdata", d_resp_rdata, 0);
        chk("rst_resp_err", d_resp_err, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;

        // MEM_LATENCY = 1
        txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, r);
        chk("lw_rdata", r.rd, 32'hDEAD_BEEF);
        chk("lw_err", r.err, 0);
        chk("lw_latency", r.lat, 2);
        chk("lw_vcyc", r.vcyc, 1);
        chk("lw_wcyc", r.wcyc, 0);
        chk("lw_addr", r.wa, 32'h8000_0010);

        txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h8012_3456, 0, r);
        chk("lb_rdata", r.rd, 32'hFFFF_FF80);
        txn(1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h8012_3456, 0, r);
        chk("lbu_rdata", r.rd, 32'h0000_0080);
        txn(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h8012_3456, 0, r);
        chk("lhu_rdata", r.rd, 32'h0000_8012);

        txn(1'b1, 3'd1, 32'h8000_0002, 32'hABCD_1234, 32'h0, 0, r);
        chk("sh_waddr", r.wa, 32'h8000_0000);
        chk("sh_wmask", r.wm, 8'h0C);
        chk("sh_wdata", r.wd, 32'h1234_0000);
        chk("sh_wcyc", r.wcyc, 1);
        chk("sh_rdata", r.rd, 0);

        txn(1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h5555_5555, 0, r);
        chk("lw_mis_err", r.err, 1);
        chk("lw_mis_lat", r.lat, 1);
        chk("lw_mis_vcyc", r.vcyc, 0);
        chk("lw_mis_rdata", r.rd, 0);
        txn(1'b1, 3'd3, 32'h8000_0000, 32'h1111_1111, 32'h0, 0, r);
        chk("st_f3_err", r.err, 1);
        chk("st_f3_vcyc", r.vcyc, 0);

        // response back-pressure, then immediate re-acceptance
        txn(1'b0, 3'd1, 32'h8000_0006, 32'h0, 32'h7FFF_1234, 5, r);
        chk("lh_hold_rdata", r.rd, 32'h0000_7FFF);
        chk("lh_hold_rdata_end", d_resp_rdata, 32'h0000_7FFF);
        txn(1'b1, 3'd0, 32'h8000_0001, 32'h0000_00A5, 32'h0, 0, r);
        chk("reaccept_wait", r.acc_wait, 0);
        chk("sb_wmask", r.wm, 8'h02);
        chk("sb_wdata", r.wd, 32'h0000_A500);
        txn(1'b0, 3'd1, 32'h8000_0000, 32'h0, 32'h0000_F00D, 0, r);
        chk("lh_neg_rdata", r.rd, 32'hFFFF_F00D);

        // MEM_LATENCY = 3
        @(negedge clk);
        #1 sel = 1'b1;
        txn(1'b0, 3'd2, 32'h8000_0030, 32'h0, 32'h0BAD_F00D, 0, r);
        chk("l3_lw_rdata", r.rd, 32'h0BAD_F00D);
        chk("l3_lw_latency", r.lat, 4);
        chk("l3_lw_vcyc", r.vcyc, 3);

        // reset in the second ACCESS cycle
        req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0020; mem_rdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_acc1_mem_valid", d_mem_valid, 1);
        @(posedge clk);
        #2;
        chk("rst_acc2_mem_valid", d_mem_valid, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_mem_valid", d_mem_valid, 0);
        chk("rst_async_mem_wen", d_mem_wen, 0);
        chk("rst_async_req_ready", d_req_ready, 1);
        chk("rst_async_resp_valid", d_resp_valid, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;

        txn(1'b1, 3'd2, 32'h8000_0040, 32'h1122_3344, 32'h0, 0, r);
        chk("l3_sw_wmask", r.wm, 8'h0F);
        chk("l3_sw_wdata", r.wd, 32'h1122_3344);
        chk("l3_sw_wcyc", r.wcyc, 1);
        chk("l3_sw_vcyc", r.vcyc, 3);
        chk("l3_sw_err", r.err, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
